// File: rtl/cic_sched_pkg.sv
// Shared types and constants for the CIC snapshot scheduler.
package cic_sched_pkg;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } sched_state_e;

    localparam int SNAP_CNT_W = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/cic_ch_holder.sv
// One channel's holding register, pending bit and sticky overrun flag.
module cic_ch_holder
    import cic_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture_i,
    input  logic                  load_snapshot_i,
    input  logic                  flag_clr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] hold_o,
    output logic                  pending_o,
    output logic                  overrun_o
);

    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  pending_q, pending_d;
    logic                  overrun_q, overrun_d;

    // load_snapshot_i clears pending; a new capture on the same edge re-arms it
    // and is not an overrun.
    always_comb begin
        hold_d    = hold_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (capture_i) begin
            hold_d    = data_i;
            pending_d = 1'b1;
        end else if (load_snapshot_i) begin
            pending_d = 1'b0;
        end
        if (capture_i && pending_q && !load_snapshot_i) begin
            overrun_d = 1'b1;
        end else if (flag_clr_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign hold_o    = hold_q;
    assign pending_o = pending_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/cic_snapshot_scheduler.sv
// Aligns N_CH CIC decimator outputs into snapshots and serializes them on one stream.
// Optional collect watchdog enabled by defining CIC_SCHED_TIMEOUT_EN.
module cic_snapshot_scheduler
    import cic_sched_pkg::*;
#(
    parameter  int N_CH           = 4,
    parameter  int DATA_WIDTH     = 16,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int CH_IDX_W       = clog2(N_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH*DATA_WIDTH-1:0] ch_data,
    input  logic [N_CH-1:0]            ch_valid,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic [CH_IDX_W-1:0]        m_ch,
    output logic                       m_sof,
    output logic                       m_valid,
    input  logic                       m_ready,
    input  logic                       flag_clr,
    output logic [N_CH-1:0]            overrun,
    output logic                       timeout,
    output logic [SNAP_CNT_W-1:0]      snap_count
);

    sched_state_e          state_q, state_d;
    logic [CH_IDX_W-1:0]   idx_q, idx_d;
    logic [SNAP_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] snap_q [N_CH];

    logic [DATA_WIDTH-1:0] hold [N_CH];
    logic [N_CH-1:0]       pending;
    logic                  load_snap;
    logic                  drop;
    logic                  clr_pending;

    assign load_snap   = (state_q == ST_COLLECT) && (&pending);
    assign clr_pending = load_snap | drop;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        cic_ch_holder #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_holder (
            .clk            (clk),
            .rst            (rst),
            .capture_i      (ch_valid[c]),
            .load_snapshot_i(clr_pending),
            .flag_clr_i     (flag_clr),
            .data_i         (ch_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .hold_o         (hold[c]),
            .pending_o      (pending[c]),
            .overrun_o      (overrun[c])
        );
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_COLLECT: begin
                if (load_snap) begin
                    state_d = ST_EMIT;
                    idx_d   = '0;
                end
            end
            ST_EMIT: begin
                if (m_ready) begin
                    if (idx_q == CH_IDX_W'(N_CH - 1)) begin
                        state_d = ST_COLLECT;
                        idx_d   = '0;
                        cnt_d   = cnt_q + SNAP_CNT_W'(1);
                    end else begin
                        idx_d = idx_q + CH_IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_COLLECT;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            idx_q   <= '0;
            cnt_q   <= '0;
            for (int unsigned c = 0; c < N_CH; c++) snap_q[c] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (load_snap) begin
                for (int unsigned c = 0; c < N_CH; c++) snap_q[c] <= hold[c];
            end
        end
    end

    assign m_valid    = (state_q == ST_EMIT);
    assign m_sof      = (state_q == ST_EMIT) && (idx_q == '0);
    assign m_ch       = idx_q;
    assign m_data     = snap_q[idx_q];
    assign snap_count = cnt_q;

`ifdef CIC_SCHED_TIMEOUT_EN
    localparam int TO_W = clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
    logic            partial;

    assign partial = (|pending) && !(&pending);

    // Counter only advances while a partial snapshot waits in COLLECT; it
    // freezes during EMIT and resets once nothing is pending.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        drop      = 1'b0;
        if (pending == '0) begin
            to_cnt_d = '0;
        end else if (state_q == ST_COLLECT) begin
            if (!partial) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                to_cnt_d = '0;
                drop     = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
        timeout_d = timeout_q;
        if (drop) begin
            timeout_d = 1'b1;
        end else if (flag_clr) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign drop               = 1'b0;
    assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_cic_snapshot_scheduler.sv
// Directed bench for cic_snapshot_scheduler (N_CH=4, DATA_WIDTH=16, TIMEOUT_CYCLES=16).
module tb_cic_snapshot_scheduler;

    logic        clk;
    logic        rst;
    logic [63:0] ch_data;
    logic [3:0]  ch_valid;
    logic [15:0] m_data;
    logic [1:0]  m_ch;
    logic        m_sof;
    logic        m_valid;
    logic        m_ready;
    logic        flag_clr;
    logic [3:0]  overrun;
    logic        timeout;
    logic [15:0] snap_count;

    int checks;
    int errors;

    cic_snapshot_scheduler #(
        .N_CH          (4),
        .DATA_WIDTH    (16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_data   (ch_data),
        .ch_valid  (ch_valid),
        .m_data    (m_data),
        .m_ch      (m_ch),
        .m_sof     (m_sof),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .flag_clr  (flag_clr),
        .overrun   (overrun),
        .timeout   (timeout),
        .snap_count(snap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cv;
        logic [63:0] d;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [1:0]  ech;
        logic        esof;
        logic [15:0] edata;
        logic [3:0]  eovr;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] cv, input logic [63:0] d, input logic rdy,
                       input logic clr, input logic ev, input logic [1:0] ech,
                       input logic esof, input logic [15:0] edata, input logic [3:0] eovr,
                       input logic [15:0] ecnt);
        vec_t v;
        v.cv = cv; v.d = d; v.rdy = rdy; v.clr = clr; v.ev = ev; v.ech = ech;
        v.esof = esof; v.edata = edata; v.eovr = eovr; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [1:0] ch, input logic sof,
                        input logic [15:0] data);
        chk({tag, "_valid"}, {63'd0, m_valid}, 64'd1);
        chk({tag, "_ch"},    {62'd0, m_ch},    {62'd0, ch});
        chk({tag, "_sof"},   {63'd0, m_sof},   {63'd0, sof});
        chk({tag, "_data"},  {48'd0, m_data},  {48'd0, data});
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ch_valid = '0;
        ch_data  = '0;
        m_ready  = 1'b0;
        flag_clr = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        ch_valid = '0;
        ch_data  = '0;
        m_ready  = 1'b0;
        flag_clr = 1'b0;
        #1;
        repeat (3) cyc();
        chk("rst_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_sof",   {63'd0, m_sof},   64'd0);
        chk("rst_data",  {48'd0, m_data},  64'd0);
        chk("rst_ovr",   {60'd0, overrun}, 64'd0);
        chk("rst_cnt",   {48'd0, snap_count}, 64'd0);
        chk("rst_to",    {63'd0, timeout}, 64'd0);
        rst = 1'b0;
        cyc();

        // all-at-once snapshot, streaming ready
        add(4'hF, 64'h0044_0033_0022_0011, 1, 0, 0, 0, 0, 16'h0000, 4'h0, 16'd0);
        add(4'h0, 64'h0,                   1, 0, 1, 0, 1, 16'h0011, 4'h0, 16'd0);
        add(4'h0, 64'h0,                   1, 0, 1, 1, 0, 16'h0022, 4'h0, 16'd0);
        add(4'h0, 64'h0,                   1, 0, 1, 2, 0, 16'h0033, 4'h0, 16'd0);
        add(4'h0, 64'h0,                   1, 0, 1, 3, 0, 16'h0044, 4'h0, 16'd0);
        add(4'h0, 64'h0,                   1, 0, 0, 0, 0, 16'h0000, 4'h0, 16'd1);
        // backpressure on beat 1 with a ch0 capture during EMIT
        add(4'hF, 64'h0044_0033_0022_0011, 1, 0, 0, 0, 0, 16'h0000, 4'h0, 16'd1);
        add(4'h0, 64'h0,                   1, 0, 1, 0, 1, 16'h0011, 4'h0, 16'd1);
        add(4'h0, 64'h0,                   1, 0, 1, 1, 0, 16'h0022, 4'h0, 16'd1);
        add(4'h1, 64'h0000_0000_0000_0055, 0, 0, 1, 1, 0, 16'h0022, 4'h0, 16'd1);
        for (int i = 0; i < 4; i++)
            add(4'h0, 64'h0,               0, 0, 1, 1, 0, 16'h0022, 4'h0, 16'd1);
        add(4'h0, 64'h0,                   1, 0, 1, 2, 0, 16'h0033, 4'h0, 16'd1);
        add(4'h0, 64'h0,                   1, 0, 1, 3, 0, 16'h0044, 4'h0, 16'd1);
        add(4'h0, 64'h0,                   1, 0, 0, 0, 0, 16'h0000, 4'h0, 16'd2);
        // ch1 overrun, then flag_clr mid-emit
        add(4'h2, 64'h0000_0000_1000_0000, 1, 0, 0, 0, 0, 16'h0000, 4'h0, 16'd2);
        add(4'h2, 64'h0000_0000_2000_0000, 1, 0, 0, 0, 0, 16'h0000, 4'h2, 16'd2);
        add(4'hC, 64'hAAAA_BBBB_0000_0000, 1, 0, 0, 0, 0, 16'h0000, 4'h2, 16'd2);
        add(4'h0, 64'h0,                   0, 0, 1, 0, 1, 16'h0055, 4'h2, 16'd2);
        add(4'h0, 64'h0,                   1, 0, 1, 1, 0, 16'h2000, 4'h2, 16'd2);
        add(4'h0, 64'h0,                   1, 1, 1, 2, 0, 16'hBBBB, 4'h0, 16'd2);
        add(4'h0, 64'h0,                   1, 0, 1, 3, 0, 16'hAAAA, 4'h0, 16'd2);
        add(4'h0, 64'h0,                   1, 0, 0, 0, 0, 16'h0000, 4'h0, 16'd3);
        // capture on the load edge (no overrun), later overrun, set beats flag_clr
        add(4'hF, 64'h0C33_0C22_0C11_0C00, 0, 0, 0, 0, 0, 16'h0000, 4'h0, 16'd3);
        add(4'h1, 64'h0000_0000_0000_0077, 0, 0, 1, 0, 1, 16'h0C00, 4'h0, 16'd3);
        add(4'h1, 64'h0000_0000_0000_0088, 0, 0, 1, 0, 1, 16'h0C00, 4'h1, 16'd3);
        add(4'h1, 64'h0000_0000_0000_0099, 0, 1, 1, 0, 1, 16'h0C00, 4'h1, 16'd3);
        add(4'h0, 64'h0,                   1, 1, 1, 1, 0, 16'h0C11, 4'h0, 16'd3);
        add(4'h0, 64'h0,                   1, 0, 1, 2, 0, 16'h0C22, 4'h0, 16'd3);
        add(4'h0, 64'h0,                   1, 0, 1, 3, 0, 16'h0C33, 4'h0, 16'd3);
        add(4'h0, 64'h0,                   1, 0, 0, 0, 0, 16'h0000, 4'h0, 16'd4);

        foreach (vecs[i]) begin
            ch_valid = vecs[i].cv;
            ch_data  = vecs[i].d;
            m_ready  = vecs[i].rdy;
            flag_clr = vecs[i].clr;
            cyc();
            chk($sformatf("v%0d_valid", i), {63'd0, m_valid}, {63'd0, vecs[i].ev});
            chk($sformatf("v%0d_ovr", i), {60'd0, overrun}, {60'd0, vecs[i].eovr});
            chk($sformatf("v%0d_cnt", i), {48'd0, snap_count}, {48'd0, vecs[i].ecnt});
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_ch", i), {62'd0, m_ch}, {62'd0, vecs[i].ech});
                chk($sformatf("v%0d_sof", i), {63'd0, m_sof}, {63'd0, vecs[i].esof});
                chk($sformatf("v%0d_data", i), {48'd0, m_data}, {48'd0, vecs[i].edata});
            end
        end
        ch_valid = '0;
        flag_clr = 1'b0;

        // staggered arrival: ch3, ch1, ch0, ch2 five cycles apart
        do_reset();
        ch_data = 64'h3333_3222_3111_3000;
        m_ready = 1'b1;
        ch_valid = 4'h8; cyc(); ch_valid = '0;
        repeat (4) begin cyc(); chk("stg_a_valid", {63'd0, m_valid}, 64'd0); end
        ch_valid = 4'h2; cyc(); ch_valid = '0;
        repeat (4) begin cyc(); chk("stg_b_valid", {63'd0, m_valid}, 64'd0); end
        ch_valid = 4'h1; cyc(); ch_valid = '0;
        repeat (4) begin cyc(); chk("stg_c_valid", {63'd0, m_valid}, 64'd0); end
        ch_valid = 4'h4; cyc(); ch_valid = '0;
        chk("stg_last_valid", {63'd0, m_valid}, 64'd0);
        cyc(); beat("stg0", 2'd0, 1'b1, 16'h3000);
        cyc(); beat("stg1", 2'd1, 1'b0, 16'h3111);
        cyc(); beat("stg2", 2'd2, 1'b0, 16'h3222);
        cyc(); beat("stg3", 2'd3, 1'b0, 16'h3333);
        cyc();
        chk("stg_end_valid", {63'd0, m_valid}, 64'd0);
        chk("stg_end_cnt", {48'd0, snap_count}, 64'd1);

        // reset mid-EMIT after two transferred beats
        ch_data = 64'h5333_5222_5111_5000;
        ch_valid = 4'hF; cyc(); ch_valid = '0;
        cyc(); beat("pre0", 2'd0, 1'b1, 16'h5000);
        cyc(); beat("pre1", 2'd1, 1'b0, 16'h5111);
        cyc(); beat("pre2", 2'd2, 1'b0, 16'h5222);
        #2 rst = 1'b1;
        #1;
        chk("mrst_valid", {63'd0, m_valid}, 64'd0);
        chk("mrst_sof",   {63'd0, m_sof},   64'd0);
        chk("mrst_ch",    {62'd0, m_ch},    64'd0);
        chk("mrst_data",  {48'd0, m_data},  64'd0);
        chk("mrst_cnt",   {48'd0, snap_count}, 64'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_valid", {63'd0, m_valid}, 64'd0);
        ch_data = 64'h4333_4222_4111_4000;
        ch_valid = 4'hF; cyc(); ch_valid = '0;
        cyc(); beat("post0", 2'd0, 1'b1, 16'h4000);
        chk("post0_cnt", {48'd0, snap_count}, 64'd0);
        repeat (3) cyc();
        cyc();
        chk("post_end_cnt", {48'd0, snap_count}, 64'd1);

        // collect watchdog
        do_reset();
        m_ready = 1'b1;
        ch_data = 64'h0000_0000_0000_0ABC;
        ch_valid = 4'h1; cyc(); ch_valid = '0;
`ifdef CIC_SCHED_TIMEOUT_EN
        repeat (15) cyc();
        chk("to_early", {63'd0, timeout}, 64'd0);
        cyc();
        chk("to_set", {63'd0, timeout}, 64'd1);
        chk("to_no_out", {63'd0, m_valid}, 64'd0);
        ch_data = 64'h6333_6222_6111_6000;
        ch_valid = 4'hE; cyc(); ch_valid = '0;
        cyc();
        chk("to_partial_dropped", {63'd0, m_valid}, 64'd0);
        chk("to_no_ovr", {60'd0, overrun}, 64'd0);
        ch_valid = 4'h1; cyc(); ch_valid = '0;
        cyc(); beat("to0", 2'd0, 1'b1, 16'h6000);
        cyc(); beat("to1", 2'd1, 1'b0, 16'h6111);
        cyc(); beat("to2", 2'd2, 1'b0, 16'h6222);
        cyc(); beat("to3", 2'd3, 1'b0, 16'h6333);
        chk("to_sticky", {63'd0, timeout}, 64'd1);
        flag_clr = 1'b1; cyc(); flag_clr = 1'b0;
        chk("to_clr", {63'd0, timeout}, 64'd0);
        chk("to_cnt", {48'd0, snap_count}, 64'd1);
`else
        repeat (20) cyc();
        chk("to_absent", {63'd0, timeout}, 64'd0);
        chk("to_wait_valid", {63'd0, m_valid}, 64'd0);
        ch_data = 64'h6333_6222_6111_0000;
        ch_valid = 4'hE; cyc(); ch_valid = '0;
        cyc(); beat("wait0", 2'd0, 1'b1, 16'h0ABC);
        cyc(); beat("wait1", 2'd1, 1'b0, 16'h6111);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
